// File: rtl/led_blink_pkg.sv
// Shared types and constants for the led_blink LED driver blocks.
package led_blink_pkg;

  typedef enum logic {
    ST_ON  = 1'b0,
    ST_OFF = 1'b1
  } blink_state_t;

  localparam int               DUTY_W    = 8;
  localparam logic [DUTY_W-1:0] DUTY_FULL = 8'hFF;

endpackage

// File: rtl/led_tick_prescaler.sv
// Free-running prescaler: count wraps every PRESCALE clocks, tick marks the last count.
module led_tick_prescaler #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int            CW   = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/led_pwm_blinker.sv
// LED driver: frame-synchronous PWM brightness plus a tick-based blink cadence.
// Define LED_PWM_FADE_EN to ramp the shadow duty toward duty_in by one step per frame.
module led_pwm_blinker
  import led_blink_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PRESCALE    = 50000,
  parameter int BLINK_TICKS = 250,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  pattern_in,
  input  logic [DUTY_W-1:0] duty_in,
  input  logic              blink_en,
  output logic [WIDTH-1:0]  led_out,
  output logic              frame_sync
);

  localparam int               BW         = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0]    PHASE_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [WIDTH-1:0] POLARITY   = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic              tick;
  logic [DUTY_W-1:0] pwm_cnt;
  logic              boundary;
  logic [WIDTH-1:0]  shadow_pattern;
  logic [DUTY_W-1:0] shadow_duty;
  logic              pwm_on;
  blink_state_t      state;
  blink_state_t      state_next;
  logic [BW-1:0]     phase_cnt;
  logic [BW-1:0]     phase_next;
  logic              blink_on;

  led_tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign boundary = (pwm_cnt == DUTY_FULL);
  assign pwm_on   = (shadow_duty == DUTY_FULL) || (pwm_cnt < shadow_duty);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt        <= '0;
      frame_sync     <= 1'b0;
      shadow_pattern <= '0;
    end else begin
      pwm_cnt    <= pwm_cnt + DUTY_W'(1);
      frame_sync <= boundary;
      if (boundary) begin
        shadow_pattern <= pattern_in;
      end
    end
  end

`ifdef LED_PWM_FADE_EN
  // Duty only moves at a frame boundary, and only if a tick arrived during that frame.
  logic tick_seen;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_seen <= 1'b0;
    end else if (boundary) begin
      tick_seen <= 1'b0;
    end else if (tick) begin
      tick_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_duty <= '0;
    end else if (boundary && (tick_seen || tick)) begin
      if (shadow_duty < duty_in) begin
        shadow_duty <= shadow_duty + DUTY_W'(1);
      end else if (shadow_duty > duty_in) begin
        shadow_duty <= shadow_duty - DUTY_W'(1);
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_duty <= '0;
    end else if (boundary) begin
      shadow_duty <= duty_in;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_ON;
      phase_cnt <= '0;
    end else begin
      state     <= state_next;
      phase_cnt <= phase_next;
    end
  end

  // Holding ON with a cleared phase while disabled makes every enable start a fresh ON phase.
  always_comb begin
    state_next = state;
    phase_next = phase_cnt;
    if (!blink_en) begin
      state_next = ST_ON;
      phase_next = '0;
    end else if (tick) begin
      if (phase_cnt == PHASE_LAST) begin
        phase_next = '0;
        state_next = (state == ST_ON) ? ST_OFF : ST_ON;
      end else begin
        phase_next = phase_cnt + BW'(1);
      end
    end
  end

  // Disabling blink bypasses the state so the pattern returns on the very next edge.
  always_comb begin
    blink_on = !blink_en || (state == ST_ON);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out <= POLARITY;
    end else begin
      led_out <= (shadow_pattern & {WIDTH{pwm_on & blink_on}}) ^ POLARITY;
    end
  end

endmodule

// File: tb/tb_led_pwm_blinker.sv
// Bench for led_pwm_blinker: table-driven PWM frames, directed corner sequences and
// randomized stimulus against a cycle-count reference model.
module tb_led_pwm_blinker;

  localparam int P  = 4;
  localparam int BT = 3;

  logic       clk        = 1'b0;
  logic       reset_n    = 1'b0;
  logic [7:0] pattern_in = 8'h00;
  logic [7:0] duty_in    = 8'h00;
  logic       blink_en   = 1'b0;
  logic [7:0] led_out;
  logic       frame_sync;

  int checks   = 0;
  int errors   = 0;
  bit model_on = 1'b0;

  typedef struct {
    logic [7:0] pattern;
    logic [7:0] duty;
    int         frames;
    int         on_cycles;
  } vec_t;

  always #5 clk = ~clk;

  led_pwm_blinker #(
    .WIDTH       (8),
    .PRESCALE    (P),
    .BLINK_TICKS (BT),
    .ACTIVE_LOW  (0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pattern_in (pattern_in),
    .duty_in    (duty_in),
    .blink_en   (blink_en),
    .led_out    (led_out),
    .frame_sync (frame_sync)
  );

  // Reference model: everything derives from the number of clocks since reset release.
  int unsigned m_n        = 0;
  int unsigned m_ticks    = 0;
  int unsigned m_pos      = 0;
  logic [7:0]  m_pat      = 8'h00;
  logic [7:0]  m_duty     = 8'h00;
  logic [7:0]  m_led      = 8'h00;
  bit          m_fs       = 1'b0;
  bit          m_seen     = 1'b0;
  bit          m_boundary = 1'b0;
  bit          m_tick     = 1'b0;
  bit          m_pwm_on   = 1'b0;
  bit          m_blink_on = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_n = 0; m_ticks = 0; m_pat = 8'h00; m_duty = 8'h00;
      m_led = 8'h00; m_fs = 1'b0; m_seen = 1'b0;
    end else begin
      m_pos      = m_n % 256;
      m_boundary = (m_pos == 255);
      m_tick     = ((m_n % P) == P - 1);
      m_pwm_on   = (m_duty == 8'hFF) || (m_pos < m_duty);
      m_blink_on = !blink_en || (((m_ticks / BT) % 2) == 0);
      m_led      = (m_pwm_on && m_blink_on) ? m_pat : 8'h00;
      m_fs       = m_boundary;
      if (m_boundary) begin
        m_pat = pattern_in;
`ifdef LED_PWM_FADE_EN
        if (m_seen || m_tick) begin
          if (m_duty < duty_in) m_duty = m_duty + 8'd1;
          else if (m_duty > duty_in) m_duty = m_duty - 8'd1;
        end
`else
        m_duty = duty_in;
`endif
        m_seen = 1'b0;
      end else if (m_tick) begin
        m_seen = 1'b1;
      end
      if (!blink_en) m_ticks = 0;
      else if (m_tick) m_ticks = m_ticks + 1;
      m_n = m_n + 1;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check_output("model_led_out", led_out, m_led);
      check_output("model_frame_sync", {31'd0, frame_sync}, {31'd0, m_fs});
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] p, input logic [7:0] d, input logic b);
    @(negedge clk);
    pattern_in = p;
    duty_in    = d;
    blink_en   = b;
  endtask

  task automatic wait_frame();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (frame_sync) begin
        ok = 1'b1;
        break;
      end
    end
    check_output("frame_sync_timeout", {31'd0, ok}, 32'd1);
  endtask

`ifndef LED_PWM_FADE_EN
  task automatic run_table();
    vec_t vecs[6];
    int on, bad, pulses, last_pulse, n;
    vecs[0] = '{8'hFF, 8'd64,  1, 64};
    vecs[1] = '{8'hA5, 8'd255, 4, 1024};
    vecs[2] = '{8'h3C, 8'd0,   2, 0};
    vecs[3] = '{8'h81, 8'd1,   1, 1};
    vecs[4] = '{8'h5A, 8'd128, 1, 128};
    vecs[5] = '{8'hC3, 8'd254, 1, 254};
    for (int v = 0; v < 6; v++) begin
      apply_stimulus(vecs[v].pattern, vecs[v].duty, 1'b0);
      wait_frame();
      on = 0; bad = 0; pulses = 0; last_pulse = 0;
      n = vecs[v].frames * 256;
      for (int j = 1; j <= n; j++) begin
        @(negedge clk);
        if (led_out == vecs[v].pattern) on++;
        else if (led_out != 8'h00) bad++;
        if (frame_sync) begin
          pulses++;
          last_pulse = j;
        end
      end
      check_output("duty_on_cycles", on, vecs[v].on_cycles);
      check_output("duty_stray_value", bad, 0);
      check_output("frame_sync_pulses", pulses, vecs[v].frames);
      check_output("frame_sync_last", last_pulse, n);
    end
  endtask

  task automatic run_glitch();
    int early;
    bit seen;
    apply_stimulus(8'h0F, 8'd255, 1'b0);
    wait_frame();
    repeat (100) @(negedge clk);
    pattern_in = 8'hF0;
    early = 0;
    seen  = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (led_out != 8'h0F) early++;
      seen = frame_sync;
    end
    check_output("glitch_sync_seen", {31'd0, seen}, 32'd1);
    check_output("glitch_early_change", early, 0);
    @(negedge clk);
    check_output("glitch_new_pattern", led_out, 8'hF0);
  endtask

  task automatic run_blink();
    bit on_arr[80];
    int tr[$];
    int bad;
    bit found;
    apply_stimulus(8'h3C, 8'd255, 1'b0);
    wait_frame();
    @(negedge clk);
    blink_en = 1'b1;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      on_arr[i] = (led_out == 8'h3C);
      if (led_out != 8'h3C && led_out != 8'h00) bad++;
      if (i > 0 && on_arr[i] != on_arr[i-1]) tr.push_back(i);
    end
    check_output("blink_stray_value", bad, 0);
    check_output("blink_enough_edges", {31'd0, tr.size() >= 4}, 32'd1);
    for (int k = 1; k < tr.size(); k++) begin
      check_output("blink_phase_len", tr[k] - tr[k-1], 2 * P * BT / 2);
    end
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      found = (led_out == 8'h00);
    end
    check_output("blink_off_seen", {31'd0, found}, 32'd1);
    blink_en = 1'b0;
    @(negedge clk);
    check_output("blink_drop_restore", led_out, 8'h3C);
  endtask

  task automatic run_reset();
    int nonzero;
    apply_stimulus(8'hA5, 8'd255, 1'b0);
    wait_frame();
    repeat (40) @(negedge clk);
    check_output("pre_reset_led", led_out, 8'hA5);
    #2 reset_n = 1'b0;
    #1;
    check_output("async_reset_led", led_out, 8'h00);
    check_output("async_reset_fs", {31'd0, frame_sync}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    nonzero = 0;
    for (int k = 1; k <= 257; k++) begin
      @(negedge clk);
      if (k < 257 && led_out != 8'h00) nonzero++;
      if (k == 256) check_output("reset_first_sync", {31'd0, frame_sync}, 32'd1);
      if (k == 257) check_output("reset_first_led", led_out, 8'hA5);
    end
    check_output("reset_dark_window", nonzero, 0);
  endtask
`else
  task automatic run_fade();
    int on;
    apply_stimulus(8'hFF, 8'd10, 1'b0);
    wait_frame();
    for (int f = 1; f <= 12; f++) begin
      on = 0;
      for (int j = 0; j < 256; j++) begin
        @(negedge clk);
        if (led_out == 8'hFF) on++;
      end
      check_output("fade_on_cycles", on, (f < 10) ? f : 10);
    end
  endtask
`endif

  task automatic run_random();
    logic [7:0] p, d;
    int sel;
    for (int s = 0; s < 20; s++) begin
      p   = 8'($urandom);
      sel = $urandom_range(0, 3);
      d   = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom);
      apply_stimulus(p, d, 1'($urandom));
      repeat ($urandom_range(50, 700)) @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        #3 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_output("reset_led_out", led_out, 8'h00);
    check_output("reset_frame_sync", {31'd0, frame_sync}, 32'd0);
    model_on = 1'b1;
    reset_n  = 1'b1;
`ifndef LED_PWM_FADE_EN
    run_table();
    run_glitch();
    run_blink();
    run_reset();
`else
    run_fade();
`endif
    run_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
